pipe_seq: RTL

Power sequencer for the wake-word pipeline, downstream of the pipeline enable controller. It turns the single enable request into an ordered bring-up: first the PDM microphone clock, then a settling wait, then the pipeline stages one at a time. On release it stops the PDM clock, waits for in-flight stages to drain (with a timeout), and disables the stages in reverse order.

---
 rtl/pipe_seq.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_seq.sv
// rtl/pipe_seq.sv - power sequencer for the wake-word pipeline
//
// Turns a level enable request into an ordered bring-up (PDM clock, warm-up
// wait, stages enabled one at a time) and an ordered shutdown (PDM clock off,
// drain with timeout, stages disabled in reverse order).
//
// Ports:
//   clk_i         system clock
//   rst_n_i       asynchronous active-low reset
//   en_i          pipeline enable request (level)
//   stage_busy_i  per-stage busy flags, bit k = stage k
//   pdm_clk_en_o  PDM clock gate enable
//   stage_en_o    per-stage enables, thermometer coded from bit 0
//   ready_o       all stages enabled
//   idle_o        fully off
//   timeout_o     one-cycle pulse when the drain times out
module pipe_seq #(
  parameter int NUM_STAGES     = 4,
  parameter int WARMUP_CYCLES  = 5,
  parameter int STAGGER_CYCLES = 2,
  parameter int DRAIN_TIMEOUT  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [NUM_STAGES-1:0] stage_busy_i,
  output logic                  pdm_clk_en_o,
  output logic [NUM_STAGES-1:0] stage_en_o,
  output logic                  ready_o,
  output logic                  idle_o,
  output logic                  timeout_o
);

  localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int CMAX = (WARMUP_CYCLES > STAGGER_CYCLES)
                      ? ((WARMUP_CYCLES > DRAIN_TIMEOUT) ? WARMUP_CYCLES : DRAIN_TIMEOUT)
                      : ((STAGGER_CYCLES > DRAIN_TIMEOUT) ? STAGGER_CYCLES : DRAIN_TIMEOUT);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    ST_OFF, ST_WARMUP, ST_RAMP, ST_RUN, ST_DRAIN, ST_RAMPDOWN
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pdm_q, pdm_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    ready_q, ready_d;
  logic                    idle_q, idle_d;
  logic                    to_q, to_d;
  logic                    drained;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      pdm_q   <= 1'b0;
      stage_q <= '0;
      ready_q <= 1'b0;
      idle_q  <= 1'b1;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pdm_q   <= pdm_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pdm_d   = pdm_q;
    stage_d = stage_q;
    ready_d = ready_q;
    idle_d  = idle_q;
    to_d    = 1'b0;
    drained = 1'b0;
    case (state_q)
      ST_OFF: begin
        if (en_i) begin
          state_d = ST_WARMUP;
          pdm_d   = 1'b1;
          idle_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_WARMUP: begin
        // A release during warm-up aborts straight to OFF; no stage is on yet.
        if (!en_i) begin
          state_d = ST_OFF;
          pdm_d   = 1'b0;
          idle_d  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q == WARM_LAST) begin
          stage_d[0] = 1'b1;
          idx_d      = '0;
          cnt_d      = '0;
          if (NUM_STAGES == 1) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            state_d = ST_RAMP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RAMP: begin
        // Release wins over a pending stage enable; enabled stages are kept.
        if (!en_i) begin
          state_d = ST_DRAIN;
          pdm_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == STAG_LAST) begin
          idx_d          = idx_q + 1'b1;
          stage_d[idx_d] = 1'b1;
          cnt_d          = '0;
          if (idx_d == IDX_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_d = ST_DRAIN;
          ready_d = 1'b0;
          pdm_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        drained = ((stage_busy_i & stage_q) == '0);
        if (drained || cnt_q == DRAIN_LAST) begin
          // A clean drain on the timeout cycle still counts as clean.
          to_d           = !drained;
          stage_d[idx_q] = 1'b0;
          cnt_d          = '0;
          if (idx_q == '0) begin
            state_d = ST_OFF;
            idle_d  = 1'b1;
          end else begin
            state_d = ST_RAMPDOWN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RAMPDOWN: begin
        if (cnt_q == STAG_LAST) begin
          idx_d          = idx_q - 1'b1;
          stage_d[idx_d] = 1'b0;
          cnt_d          = '0;
          if (idx_d == '0) begin
            state_d = ST_OFF;
            idle_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  assign pdm_clk_en_o = pdm_q;
  assign stage_en_o   = stage_q;
  assign ready_o      = ready_q;
  assign idle_o       = idle_q;
  assign timeout_o    = to_q;

endmodule
